// File: rtl/vga_plot_arbiter_if.sv
// Requester-side handshake bus and adapter-side pixel bus of the plot arbiter.
// slave = arbiter side, master = requesters / adapter environment.
interface vga_plot_arbiter_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 9
);
  logic [1:0]           req_valid;
  logic [2*X_W-1:0]     req_x;
  logic [2*Y_W-1:0]     req_y;
  logic [2*COLOR_W-1:0] req_colour;
  logic [1:0]           req_ready;
  logic [X_W-1:0]       vga_x;
  logic [Y_W-1:0]       vga_y;
  logic [COLOR_W-1:0]   vga_colour;
  logic                 vga_plot;

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready, vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin share of the VGA pixel-write port between two requesters, with a
// full-frame clear sweep that preempts both. Optional range check: PLOT_BOUNDS_CHECK_EN.
module vga_plot_arbiter #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 9,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  vga_plot_arbiter_if.slave  bus,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_colour,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               oob_err
);
  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic               last_grant;
  logic [X_W-1:0]     cx;
  logic [Y_W-1:0]     cy;
  logic [COLOR_W-1:0] clr_col;
  logic [X_W-1:0]     vx;
  logic [Y_W-1:0]     vy;
  logic [COLOR_W-1:0] vc;
  logic               vplot;

  logic [1:0][X_W-1:0]     lx;
  logic [1:0][Y_W-1:0]     ly;
  logic [1:0][COLOR_W-1:0] lc;
  logic [1:0]              ready;
  logic                    idle_ok;
  logic                    sel;
  logic                    oob;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign lx[i] = bus.req_x[i*X_W +: X_W];
    assign ly[i] = bus.req_y[i*Y_W +: Y_W];
    assign lc[i] = bus.req_colour[i*COLOR_W +: COLOR_W];
  end

  // resetn gates ready so no handshake can complete while the block is held in reset
  always_comb begin
    idle_ok  = resetn & (state == IDLE) & ~clear_start;
    ready[0] = idle_ok & bus.req_valid[0] & (~bus.req_valid[1] | last_grant);
    ready[1] = idle_ok & bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
    sel      = ready[1];
  end

`ifdef PLOT_BOUNDS_CHECK_EN
  logic oob_q;
  assign oob     = ({1'b0, lx[sel]} >= (X_W+1)'(X_MAX)) | ({1'b0, ly[sel]} >= (Y_W+1)'(Y_MAX));
  assign oob_err = oob_q;
`else
  assign oob     = 1'b0;
  assign oob_err = 1'b0;
`endif

  assign bus.req_ready  = ready;
  assign bus.vga_x      = vx;
  assign bus.vga_y      = vy;
  assign bus.vga_colour = vc;
  assign bus.vga_plot   = vplot;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cx         <= '0;
      cy         <= '0;
      clr_col    <= '0;
      vx         <= '0;
      vy         <= '0;
      vc         <= '0;
      vplot      <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
`ifdef PLOT_BOUNDS_CHECK_EN
      oob_q      <= 1'b0;
`endif
    end else begin
      vplot      <= 1'b0;
      clear_done <= 1'b0;
`ifdef PLOT_BOUNDS_CHECK_EN
      oob_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_col    <= clear_colour;
            cx         <= '0;
            cy         <= '0;
            clear_busy <= 1'b1;
          end else if (|ready) begin
            last_grant <= sel;
            if (oob) begin
`ifdef PLOT_BOUNDS_CHECK_EN
              oob_q <= 1'b1;
`endif
            end else begin
              vplot <= 1'b1;
              vx    <= lx[sel];
              vy    <= ly[sel];
              vc    <= lc[sel];
            end
          end
        end
        CLEAR: begin
          // clear_start is deliberately ignored here: no restart, no colour re-latch
          vplot <= 1'b1;
          vx    <= cx;
          vy    <= cy;
          vc    <= clr_col;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy         <= '0;
              state      <= IDLE;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
            end else begin
              cy <= cy + Y_W'(1);
            end
          end else begin
            cx <= cx + X_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: ready vector table, scoreboard of expected pixels
// with due cycles, and hand-written clear/collision/reset/bounds sequences.
module tb_vga_plot_arbiter;
  localparam int X_W = 8, Y_W = 7, COLOR_W = 9;
  localparam int NPIX = 160 * 120;

  logic               CLOCK_50 = 1'b0;
  logic               resetn   = 1'b0;
  logic               clear_start = 1'b0;
  logic [COLOR_W-1:0] clear_colour = '0;
  logic               clear_busy, clear_done, oob_err;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus();

  vga_plot_arbiter #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .X_MAX(160), .Y_MAX(120)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_colour(clear_colour),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .oob_err     (oob_err)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    int         due;
  } pix_t;

  typedef struct {
    logic [1:0] v;
    logic [1:0] exp;
  } vec_t;

  pix_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [8:0] c, input int due);
    pix_t p;
    p.x = x; p.y = y; p.c = c; p.due = due;
    sb.push_back(p);
  endtask

  task automatic set_req(input logic [1:0] v,
                         input logic [7:0] x0, input logic [6:0] y0, input logic [8:0] c0,
                         input logic [7:0] x1, input logic [6:0] y1, input logic [8:0] c1);
    bus.req_valid  = v;
    bus.req_x      = {x1, x0};
    bus.req_y      = {y1, y0};
    bus.req_colour = {c1, c0};
  endtask

  // Drives one cycle of requests with random coordinates, pushes the winner the
  // bench expects and checks the combinational ready against that expectation.
  task automatic req_step(input string name, input logic [1:0] v, input logic [1:0] exp);
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [8:0] c0, c1;
    @(posedge CLOCK_50); #1;
    x0 = 8'($urandom_range(0, 159)); y0 = 7'($urandom_range(0, 119)); c0 = 9'($urandom);
    x1 = 8'($urandom_range(0, 159)); y1 = 7'($urandom_range(0, 119)); c1 = 9'($urandom);
    clear_start = 1'b0;
    set_req(v, x0, y0, c0, x1, y1, c1);
    if (exp[0])      push(x0, y0, c0, cyc + 1);
    else if (exp[1]) push(x1, y1, c1, cyc + 1);
    @(negedge CLOCK_50);
    chk(name, bus.req_ready, exp);
  endtask

  // Pixel monitor: every plot must match the scoreboard head on its due cycle.
  always @(negedge CLOCK_50) begin
    pix_t p;
    if (mon_en) begin
      if (bus.vga_plot === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_plot actual=(%0d,%0d) expected=none cycle=%0d", bus.vga_x, bus.vga_y, cyc);
        end else begin
          p = sb.pop_front();
          chk("plot_x", bus.vga_x, p.x);
          chk("plot_y", bus.vga_y, p.y);
          chk("plot_colour", bus.vga_colour, p.c);
          chk("plot_cycle", cyc, p.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        p = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_plot actual=plot0 expected=(%0d,%0d) cycle=%0d", p.x, p.y, cyc);
      end
    end
  end

  task automatic sweep(input logic [8:0] col, input bit collide, input int restart_at, input int abort_at);
    int k;
    @(posedge CLOCK_50); #1;
    clear_start  = 1'b1;
    clear_colour = col;
    set_req(collide ? 2'b01 : 2'b00, 8'd3, 7'd4, 9'h15, 8'd5, 7'd6, 9'h16);
    k = cyc;
    for (int i = 0; i < NPIX; i++) push(8'(i % 160), 7'(i / 160), col, k + 2 + i);
    @(negedge CLOCK_50);
    chk("clr_start_ready", bus.req_ready, 2'b00);
    for (int n = 1; n <= NPIX; n++) begin
      @(posedge CLOCK_50); #1;
      clear_start  = (n == restart_at);
      clear_colour = 9'h0AA;
      bus.req_valid = 2'b11;
      if (n == abort_at) begin
        resetn = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("abort_plot", bus.vga_plot, 1'b0);
        chk("abort_busy", clear_busy, 1'b0);
        sb.delete();
        clear_start = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge CLOCK_50);
          chk("abort_no_done", clear_done, 1'b0);
          chk("abort_plot_low", bus.vga_plot, 1'b0);
        end
        @(posedge CLOCK_50); #1;
        bus.req_valid = 2'b00;
        resetn = 1'b1;
        mon_en = 1'b1;
        return;
      end
      @(negedge CLOCK_50);
      chk("sweep_ready", bus.req_ready, 2'b00);
      chk("sweep_busy", clear_busy, 1'b1);
      chk("sweep_done_low", clear_done, 1'b0);
    end
    @(posedge CLOCK_50); #1;
    clear_start = 1'b0;
    set_req(2'b01, 8'd77, 7'd66, 9'h123, 8'd1, 7'd1, 9'h0);
    push(8'd77, 7'd66, 9'h123, cyc + 1);
    @(negedge CLOCK_50);
    chk("done_pulse", clear_done, 1'b1);
    chk("done_busy", clear_busy, 1'b0);
    chk("done_ready", bus.req_ready, 2'b01);
    @(posedge CLOCK_50); #1;
    bus.req_valid = 2'b00;
    @(negedge CLOCK_50);
    chk("done_single", clear_done, 1'b0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2'b00, 2'b00};
    tbl[1] = '{2'b10, 2'b10};
    tbl[2] = '{2'b11, 2'b01};
    tbl[3] = '{2'b11, 2'b10};
    tbl[4] = '{2'b01, 2'b01};
    tbl[5] = '{2'b01, 2'b01};
    tbl[6] = '{2'b11, 2'b10};
    tbl[7] = '{2'b10, 2'b10};
    tbl[8] = '{2'b11, 2'b01};
    tbl[9] = '{2'b00, 2'b00};

    // reset with random inputs
    set_req(2'b00, 8'd0, 7'd0, 9'd0, 8'd0, 7'd0, 9'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLOCK_50); #1;
      set_req(2'($urandom), 8'($urandom), 7'($urandom), 9'($urandom), 8'($urandom), 7'($urandom), 9'($urandom));
      clear_start  = 1'($urandom);
      clear_colour = 9'($urandom);
      @(negedge CLOCK_50);
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_plot", bus.vga_plot, 1'b0);
      chk("rst_xyc", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
      chk("rst_busy_done_oob", {clear_busy, clear_done, oob_err}, 3'b000);
    end
    clear_start = 1'b0;
    set_req(2'b01, 8'd1, 7'd2, 9'h3, 8'd9, 7'd9, 9'h9);
    resetn = 1'b1;
    #1;
    chk("rst_release_ready", bus.req_ready, 2'b01);
    push(8'd1, 7'd2, 9'h3, cyc + 1);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) req_step("tbl_ready", tbl[i].v, tbl[i].exp);

    // single write
    @(posedge CLOCK_50); #1;
    set_req(2'b01, 8'd10, 7'd20, 9'h1FF, 8'd0, 7'd0, 9'd0);
    push(8'd10, 7'd20, 9'h1FF, cyc + 1);
    @(negedge CLOCK_50);
    chk("single_ready", bus.req_ready, 2'b01);
    req_step("single_idle", 2'b00, 2'b00);
    req_step("single_idle2", 2'b00, 2'b00);
    chk("single_plot_low", bus.vga_plot, 1'b0);

    // contention: a req1 grant first so requester 0 leads the alternation
    req_step("pre_contend", 2'b10, 2'b10);
    for (int i = 0; i < 6; i++) req_step("contend", 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10);
    req_step("contend_end", 2'b00, 2'b00);

    sweep(9'h007, 1'b0, 0, 0);
    sweep(9'h1C3, 1'b1, 1000, 0);
    sweep(9'h055, 1'b0, 0, 502);

    // out-of-range pixel from requester 1
    @(posedge CLOCK_50); #1;
    set_req(2'b10, 8'd0, 7'd0, 9'd0, 8'd160, 7'd5, 9'h0F0);
`ifndef PLOT_BOUNDS_CHECK_EN
    push(8'd160, 7'd5, 9'h0F0, cyc + 1);
`endif
    @(negedge CLOCK_50);
    chk("oob_ready", bus.req_ready, 2'b10);
    @(posedge CLOCK_50); #1;
    bus.req_valid = 2'b00;
    @(negedge CLOCK_50);
`ifdef PLOT_BOUNDS_CHECK_EN
    chk("oob_plot", bus.vga_plot, 1'b0);
    chk("oob_err", oob_err, 1'b1);
    chk("oob_hold_x", bus.vga_x, 8'd0);
`else
    chk("oob_plot", bus.vga_plot, 1'b1);
    chk("oob_x", bus.vga_x, 8'd160);
    chk("oob_err", oob_err, 1'b0);
`endif
    @(negedge CLOCK_50);
    chk("oob_err_clear", oob_err, 1'b0);

    repeat (3) @(negedge CLOCK_50);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
